// File: rtl/vga_glyph_pkg.sv
// Shared geometry, derived decode points and clear-engine state type for the
// glyph display text RAM arbiter.
package vga_glyph_pkg;

  localparam int unsigned H_START  = 160;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned CELL     = 8;
  localparam int unsigned COLS     = H_ACTIVE / CELL;
  localparam int unsigned ROWS     = V_ACTIVE / CELL;
  localparam int unsigned CELLS    = COLS * ROWS;
  localparam int unsigned ADDR_W   = 13;

  localparam logic [7:0] CLR_CHAR = 8'h20;

  // A cell is fetched one cell ahead of the beam and shown on its own boundary.
  localparam logic [9:0] FETCH_H_FIRST = 10'(H_START - CELL);
  localparam logic [9:0] FETCH_H_LAST  = 10'(H_START - CELL + CELL * (COLS - 1));
  localparam logic [9:0] LOAD_H_FIRST  = 10'(H_START);
  localparam logic [9:0] LOAD_H_LAST   = 10'(H_START + CELL * (COLS - 1));

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clr_state_e;

endpackage

// File: rtl/glyph_ram_arbiter_if.sv
// Host command bus of the glyph RAM arbiter.
//   hst_valid/hst_ready : request handshake (valid must not wait on ready)
//   hst_we/addr/wdata   : command
//   hst_rvalid/hst_rdata: read response, one cycle after acceptance
interface glyph_ram_arbiter_if;
  import vga_glyph_pkg::*;

  logic              hst_valid;
  logic              hst_ready;
  logic              hst_we;
  logic [ADDR_W-1:0] hst_addr;
  logic [7:0]        hst_wdata;
  logic              hst_rvalid;
  logic [7:0]        hst_rdata;

  modport master (
    output hst_valid, hst_we, hst_addr, hst_wdata,
    input  hst_ready, hst_rvalid, hst_rdata
  );

  modport slave (
    input  hst_valid, hst_we, hst_addr, hst_wdata,
    output hst_ready, hst_rvalid, hst_rdata
  );

endinterface

// File: rtl/text_addr_gen.sv
// Display fetch sequencer. Decodes the pixel counters into a one-cycle fetch
// request one cell ahead of the beam and produces the text RAM address from a
// running row base plus column counter (no multiplier).
//   pix_ce/hcount/vcount : VGA timing inputs
//   fetch_req/fetch_addr : display read request and address
//   cell_load            : cell boundary, move staged code to the renderer
module text_addr_gen
  import vga_glyph_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              cell_load
);

  logic [ADDR_W-1:0] row_base_q, row_base_d, row_base_now;
  logic [6:0]        col_q, col_d, col_now;
  logic              active_line;

  always_comb begin
    active_line = pix_ce && (vcount < 10'(V_ACTIVE));
    fetch_req   = active_line && (hcount >= FETCH_H_FIRST) && (hcount <= FETCH_H_LAST) &&
                  (hcount[2:0] == 3'd0);
    cell_load   = active_line && (hcount >= LOAD_H_FIRST) && (hcount <= LOAD_H_LAST) &&
                  (hcount[2:0] == 3'd0);

    // The first fetch of a line picks the row base for the whole line: restart
    // at the top of the frame, step one text row on each new glyph row.
    row_base_now = row_base_q;
    col_now      = col_q;
    if (hcount == FETCH_H_FIRST) begin
      col_now = '0;
      if (vcount == '0) begin
        row_base_now = '0;
      end else if (vcount[2:0] == 3'd0) begin
        row_base_now = row_base_q + ADDR_W'(COLS);
      end
    end
    fetch_addr = row_base_now + ADDR_W'(col_now);

    row_base_d = row_base_q;
    col_d      = col_q;
    if (fetch_req) begin
      row_base_d = row_base_now;
      col_d      = col_now + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base_q <= '0;
      col_q      <= '0;
    end else begin
      row_base_q <= row_base_d;
      col_q      <= col_d;
    end
  end

endmodule

// File: rtl/glyph_ram_arbiter.sv
// Shares the single-port text RAM between display fetch (highest priority),
// the clear-screen engine and the host port, and delivers each cell's
// character code to the glyph renderer on the cell boundary.
//   clk/rst_n             : clock, async active-low reset
//   pix_ce/hcount/vcount  : VGA timing inputs
//   ram_*                 : RAM port (read data valid the cycle after address)
//   char_code/glyph_row   : renderer outputs
//   hst                   : host command bus
//   clr_start/clr_busy    : clear-screen control
//   err_oob               : sticky out-of-range host address flag
module glyph_ram_arbiter
  import vga_glyph_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_ce,
  input  logic [9:0]          hcount,
  input  logic [9:0]          vcount,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [7:0]          ram_wdata,
  input  logic [7:0]          ram_rdata,
  output logic [7:0]          char_code,
  output logic [2:0]          glyph_row,
  glyph_ram_arbiter_if.slave  hst,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                err_oob
);

  logic              fetch_req, cell_load;
  logic [ADDR_W-1:0] fetch_addr;

  text_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_ce    (pix_ce),
    .hcount    (hcount),
    .vcount    (vcount),
    .fetch_req (fetch_req),
    .fetch_addr(fetch_addr),
    .cell_load (cell_load)
  );

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [7:0]        stage_q, stage_d;
  logic [7:0]        char_q, char_d;
  logic [2:0]        row_q, row_d;
  logic              fetch_pend_q, fetch_pend_d;
  logic              hrd_pend_q, hrd_pend_d;
  logic              hrd_oob_q, hrd_oob_d;
  logic              err_q, err_d;
  logic              host_acc, host_oob, clr_write;

  always_comb begin
    hst.hst_ready = !fetch_req && (state_q == StIdle);
    host_acc      = hst.hst_valid && hst.hst_ready;
    host_oob      = hst.hst_addr >= ADDR_W'(CELLS);
    clr_write     = (state_q == StClear) && !fetch_req;

    // RAM port mux; the address holds when nobody owns the port.
    ram_addr  = last_addr_q;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (fetch_req) begin
      ram_addr = fetch_addr;
    end else if (clr_write) begin
      ram_addr  = clr_addr_q;
      ram_we    = 1'b1;
      ram_wdata = CLR_CHAR;
    end else if (host_acc && !host_oob) begin
      ram_addr  = hst.hst_addr;
      ram_we    = hst.hst_we;
      ram_wdata = hst.hst_we ? hst.hst_wdata : 8'h00;
    end
    last_addr_d = ram_addr;

    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      StClear: begin
        if (clr_write) begin
          if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
            state_d    = StIdle;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    err_d        = err_q || (host_acc && host_oob);
    fetch_pend_d = fetch_req;
    hrd_pend_d   = host_acc && !hst.hst_we;
    hrd_oob_d    = host_acc && !hst.hst_we && host_oob;

    stage_d = fetch_pend_q ? ram_rdata : stage_q;
    char_d  = char_q;
    row_d   = row_q;
    if (cell_load) begin
      char_d = stage_q;
      row_d  = vcount[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      clr_addr_q   <= '0;
      last_addr_q  <= '0;
      stage_q      <= '0;
      char_q       <= '0;
      row_q        <= '0;
      fetch_pend_q <= 1'b0;
      hrd_pend_q   <= 1'b0;
      hrd_oob_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      last_addr_q  <= last_addr_d;
      stage_q      <= stage_d;
      char_q       <= char_d;
      row_q        <= row_d;
      fetch_pend_q <= fetch_pend_d;
      hrd_pend_q   <= hrd_pend_d;
      hrd_oob_q    <= hrd_oob_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    char_code      = char_q;
    glyph_row      = row_q;
    clr_busy       = (state_q == StClear);
    err_oob        = err_q;
    hst.hst_rvalid = hrd_pend_q;
    // RAM data arrives this cycle for the read accepted last cycle.
    hst.hst_rdata  = (hrd_pend_q && !hrd_oob_q) ? ram_rdata : 8'h00;
  end

endmodule

// File: tb/tb_glyph_ram_arbiter.sv
// Randomized bench for glyph_ram_arbiter with a RAM model, a cell-level
// reference of the text map and a scoreboard for display and host responses.
module tb_glyph_ram_arbiter;
  import vga_glyph_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_ce = 1'b0;
  logic [9:0]        hcount = '0;
  logic [9:0]        vcount = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata = 8'h00;
  logic [7:0]        char_code;
  logic [2:0]        glyph_row;
  logic              clr_start = 1'b0;
  logic              clr_busy;
  logic              err_oob;

  glyph_ram_arbiter_if hst ();

  glyph_ram_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_ce   (pix_ce),
    .hcount   (hcount),
    .vcount   (vcount),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .char_code(char_code),
    .glyph_row(glyph_row),
    .hst      (hst),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .err_oob  (err_oob)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write.
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference state
  typedef struct {
    int         v;
    int         k;
    logic [7:0] code;
  } disp_t;

  logic [7:0] ref_mem [0:8191];
  disp_t      disp_q[$];
  logic [7:0] rd_q[$];
  bit         exp_busy, exp_err, cell_pend, clr_done_chk;
  int         clr_next, cell_v, cell_k;
  int         exp_last;

  int         m_v, m_h, m_k, m_a, m_bad;
  bit         m_trig, m_bnd, m_acc, m_ready, m_busy, m_found;
  disp_t      m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_busy = 0; exp_err = 0; exp_last = 0; clr_next = 0;
      cell_pend = 0; clr_done_chk = 0;
      disp_q.delete(); rd_q.delete();
    end else begin
      // Responses to the previous cycle
      if (cell_pend) begin
        m_found = 0;
        while (disp_q.size() > 0 && !m_found) begin
          m_e = disp_q.pop_front();
          if (m_e.v == cell_v && m_e.k == cell_k) m_found = 1;
        end
        if (!m_found) begin
          vectors++; miscompares++;
          $display("FAIL cell_missing: line %0d cell %0d had no fetch", cell_v, cell_k);
        end else begin
          chk("char_code", char_code, m_e.code);
          chk("glyph_row", glyph_row, cell_v % 8);
        end
        cell_pend = 0;
      end
      if (hst.hst_rvalid) begin
        if (rd_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL host_rvalid: got 1, expected 0 (no read pending)");
        end else begin
          chk("host_rdata", hst.hst_rdata, rd_q.pop_front());
        end
      end
      if (clr_done_chk) begin
        m_bad = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== CLR_CHAR) m_bad++;
        chk("clear_fill_bad_cells", m_bad, 0);
        clr_done_chk = 0;
      end
      chk("clr_busy", clr_busy, exp_busy);
      chk("err_oob", err_oob, exp_err);

      // This cycle
      m_busy  = exp_busy;
      m_v     = vcount;
      m_h     = hcount;
      m_trig  = pix_ce && m_v < 480 && m_h >= 152 && m_h <= 784 && m_h % 8 == 0;
      m_bnd   = pix_ce && m_v < 480 && m_h >= 160 && m_h <= 792 && m_h % 8 == 0;
      m_ready = !m_trig && !m_busy;
      chk("hst_ready", hst.hst_ready, m_ready);
      m_acc = hst.hst_valid && m_ready;
      if (m_trig) begin
        m_k = (m_h - 152) / 8;
        m_a = (m_v / 8) * 80 + m_k;
        chk("fetch_addr", ram_addr, m_a);
        chk("fetch_we", ram_we, 0);
        disp_q.push_back('{v: m_v, k: m_k, code: ref_mem[m_a]});
        exp_last = m_a;
      end else if (m_busy) begin
        chk("clear_addr", ram_addr, clr_next);
        chk("clear_we", ram_we, 1);
        chk("clear_wdata", ram_wdata, 8'h20);
        ref_mem[clr_next] = 8'h20;
        exp_last = clr_next;
        clr_next++;
        if (clr_next == CELLS) begin
          exp_busy = 0;
          clr_done_chk = 1;
        end
      end else if (m_acc && hst.hst_addr < CELLS) begin
        m_a = hst.hst_addr;
        chk("host_addr", ram_addr, m_a);
        chk("host_we", ram_we, hst.hst_we);
        if (hst.hst_we) begin
          chk("host_wdata", ram_wdata, hst.hst_wdata);
          ref_mem[m_a] = hst.hst_wdata;
        end else begin
          rd_q.push_back(ref_mem[m_a]);
        end
        exp_last = m_a;
      end else begin
        chk("addr_hold", ram_addr, exp_last);
        chk("idle_we", ram_we, 0);
      end
      if (m_acc && hst.hst_addr >= CELLS) begin
        exp_err = 1;
        if (!hst.hst_we) rd_q.push_back(8'h00);
      end
      if (m_bnd) begin
        cell_pend = 1;
        cell_v = m_v;
        cell_k = (m_h - 160) / 8;
      end
      if (clr_start && !m_busy) begin
        exp_busy = 1;
        clr_next = 0;
      end
    end
  end

  // Host driver: valid is raised independently of ready and held until taken.
  task automatic host_txn(input bit w, input int a, input logic [7:0] d);
    int n = 0;
    hst.hst_valid = 1'b1;
    hst.hst_we    = w;
    hst.hst_addr  = 13'(a);
    hst.hst_wdata = d;
    @(negedge clk);
    while (!hst.hst_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!hst.hst_ready) begin
      vectors++; miscompares++;
      $display("FAIL host_timeout: got no grant, expected grant within 20000 cycles");
    end
    @(posedge clk);
    #1;
    hst.hst_valid = 1'b0;
  endtask

  bit host_go = 0;
  bit host_idle = 0;

  initial begin : host_proc
    hst.hst_valid = 1'b0;
    hst.hst_we    = 1'b0;
    hst.hst_addr  = '0;
    hst.hst_wdata = '0;
    wait (host_go);
    tick();
    host_txn(1, 100, 8'h7E);
    host_txn(0, 100, 8'h00);
    host_txn(0, 4800, 8'h00);
    while (host_go) begin
      repeat ($urandom_range(0, 6)) tick();
      if (!host_go) break;
      if ($urandom_range(0, 7) == 0)
        host_txn($urandom_range(0, 1) == 1, $urandom_range(4800, 8191), 8'($urandom));
      else if ($urandom_range(0, 1) == 1)
        host_txn($urandom_range(0, 1) == 1, $urandom_range(0, 63), 8'($urandom));
      else
        host_txn($urandom_range(0, 1) == 1, $urandom_range(0, 4799), 8'($urandom));
    end
    host_idle = 1;
  end

  // One scan line: pix_ce high every second clk, counter steps after it.
  task automatic sweep(input int v, input int hlo, input int hhi);
    vcount = 10'(v);
    for (int h = hlo; h <= hhi; h++) begin
      hcount = 10'(h);
      pix_ce = 1'b0;
      tick();
      pix_ce = 1'b1;
      tick();
    end
    pix_ce = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
  endtask

  initial begin : main_proc
    int n;
    bit full;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[0] = 8'h41;
    ref_mem[0] = 8'h41;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Frame with full lines at chosen spots, k=0 only elsewhere.
    for (int v = 0; v <= 480; v++) begin
      full = (v == 0) || (v == 17) || (v == 40) || (v == 479) || (v == 480);
      sweep(v, 148, full ? 795 : 160);
      if (v == 0) host_go = 1;
      if (v == 10 || v == 14) pulse_clr();
    end

    host_go = 0;
    n = 0;
    while (!host_idle && n < 30000) begin
      tick();
      n++;
    end
    if (!host_idle) begin
      vectors++; miscompares++;
      $display("FAIL host_drain: got busy host, expected idle");
    end

    // Abort a clear with reset.
    pulse_clr();
    repeat (200) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_char_code", char_code, 0);
    chk("rst_glyph_row", glyph_row, 0);
    chk("rst_hst_rvalid", hst.hst_rvalid, 0);
    chk("rst_hst_rdata", hst.hst_rdata, 0);
    chk("rst_err_oob", err_oob, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    host_txn(0, 100, 8'h00);
    host_txn(0, 4799, 8'h00);
    for (int v = 0; v <= 9; v++) sweep(v, 148, (v == 8) ? 795 : 160);
    host_txn(0, 4800, 8'h00);
    host_txn(1, 7, 8'h5A);
    host_txn(0, 7, 8'h00);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    miscompares++;
    $display("FAIL watchdog: got no finish, expected finish before 3 ms");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
